// File: rtl/spi_burst_sequencer_if.sv
// Bus bundle between the host/register side, the burst sequencer and the SPI byte engine.
// Ports: command (cmd_*), TX byte stream (tx_*), RX strobe (rx_*), status (done/busy),
//        engine side (cs_n, spi_start, spi_data_in, spi_new_data, spi_data_out).
interface spi_burst_sequencer_if #(
    parameter int LEN_WIDTH = 8
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [LEN_WIDTH-1:0] cmd_len;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [7:0]           tx_data;
    logic                 rx_valid;
    logic [7:0]           rx_data;
    logic                 done;
    logic                 busy;
    logic                 cs_n;
    logic                 spi_start;
    logic [7:0]           spi_data_in;
    logic                 spi_new_data;
    logic [7:0]           spi_data_out;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_len, tx_valid, tx_data, spi_new_data, spi_data_out,
        output cmd_ready, tx_ready, rx_valid, rx_data, done, busy, cs_n, spi_start, spi_data_in
    );

    // Host plus engine side.
    modport master (
        output cmd_valid, cmd_len, tx_valid, tx_data, spi_new_data, spi_data_out,
        input  cmd_ready, tx_ready, rx_valid, rx_data, done, busy, cs_n, spi_start, spi_data_in
    );
endinterface

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer: runs an N-byte SPI transfer through a single-byte engine, owning cs_n timing.
// Latency: command acceptance to first spi_start is CS_SETUP+2 cycles with tx_valid already high.
// Backpressure: stalls in LOAD (cs_n held low) until tx_valid; RX strobe has no backpressure.
// Ports: clk, rst (async active-low), bus (slave modport of spi_burst_sequencer_if).
module spi_burst_sequencer #(
    parameter int LEN_WIDTH = 8,
    parameter int CS_SETUP  = 4,
    parameter int CS_HOLD   = 4,
    parameter int GAP       = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_burst_sequencer_if.slave  bus
);
    localparam int TMAX_SH = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int TMAX    = (TMAX_SH > GAP) ? TMAX_SH : GAP;
    localparam int TW      = $clog2(TMAX + 1);

    // Terminal counts: a phase of P cycles ends when the timer reaches P-1.
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'((GAP > 0) ? (GAP - 1) : 0);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        WAIT_DONE,
        GAP_W,
        HOLD
    } state_t;

    state_t               state;
    logic [LEN_WIDTH-1:0] remaining;
    logic [TW-1:0]        timer;

    assign bus.cmd_ready = (state == IDLE);
    assign bus.tx_ready  = (state == LOAD);
    assign bus.busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            remaining       <= '0;
            timer           <= '0;
            bus.cs_n        <= 1'b1;
            bus.spi_start   <= 1'b0;
            bus.spi_data_in <= 8'h00;
            bus.rx_valid    <= 1'b0;
            bus.rx_data     <= 8'h00;
            bus.done        <= 1'b0;
        end else begin
            // Strobes default low so each is exactly one cycle wide.
            bus.spi_start <= 1'b0;
            bus.rx_valid  <= 1'b0;
            bus.done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        remaining <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            // Empty burst: completes without touching chip select.
                            bus.done <= 1'b1;
                        end else begin
                            bus.cs_n <= 1'b0;
                            timer    <= '0;
                            state    <= SETUP;
                        end
                    end
                end

                SETUP: begin
                    if (timer == SETUP_LAST) begin
                        timer <= '0;
                        state <= LOAD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                LOAD: begin
                    if (bus.tx_valid) begin
                        bus.spi_data_in <= bus.tx_data;
                        bus.spi_start   <= 1'b1;
                        state           <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.spi_new_data) begin
                        bus.rx_data  <= bus.spi_data_out;
                        bus.rx_valid <= 1'b1;
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_WIDTH'(1);
                        end
                        timer <= '0;
                        // remaining==0 cannot occur here; treating it as last keeps the count from wrapping.
                        if (remaining <= LEN_WIDTH'(1)) begin
                            state <= HOLD;
                        end else if (GAP > 0) begin
                            state <= GAP_W;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end

                GAP_W: begin
                    if (timer == GAP_LAST) begin
                        timer <= '0;
                        state <= LOAD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                HOLD: begin
                    if (timer == HOLD_LAST) begin
                        timer    <= '0;
                        bus.cs_n <= 1'b1;
                        bus.done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                default: begin
                    bus.cs_n <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer: directed bursts, a loopback engine, a timestamp-based model
// checked every cycle on the falling edge, plus hand-computed literal expectations per scenario.
module tb_spi_burst_sequencer;
    localparam int CS_SETUP = 4;
    localparam int CS_HOLD  = 4;
    localparam int GAP      = 2;
    localparam int ENG_LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    spi_burst_sequencer_if #(.LEN_WIDTH(8)) bus_if ();

    spi_burst_sequencer #(
        .LEN_WIDTH (8),
        .CS_SETUP  (CS_SETUP),
        .CS_HOLD   (CS_HOLD),
        .GAP       (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t: wait bound expired", name, $time);
    endtask

    // ---------------- loopback engine ----------------
    int         eng_cnt  = 0;
    logic [7:0] eng_byte = 8'h00;
    bit         spur_req = 1'b0;

    initial begin
        bus_if.spi_new_data = 1'b0;
        bus_if.spi_data_out = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            bus_if.spi_new_data = 1'b0;
            if (!rst) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        bus_if.spi_new_data = 1'b1;
                        bus_if.spi_data_out = eng_byte;
                    end
                end
                if (spur_req) begin
                    bus_if.spi_new_data = 1'b1;
                    bus_if.spi_data_out = 8'hEE;
                    spur_req = 1'b0;
                end
                if (bus_if.spi_start) begin
                    eng_cnt  = ENG_LAT;
                    eng_byte = bus_if.spi_data_in;
                end
            end
        end
    end

    // ---------------- model + monitor ----------------
    // The model tracks absolute cycle numbers at which things must happen.
    int         cyc = 0;
    bit         m_active = 0, m_fin = 0, m_fly = 0;
    int         m_left = 0, m_load_at = 0;
    int         m_start_at = -100, m_rx_at = -100, m_done_at = -100;
    logic [7:0] m_din = 8'h00, m_rx = 8'h00;
    bit         e_txr;

    int         mon_start = 0, mon_rx = 0, mon_done = 0, mon_cs_low = 0;
    int         mon_acc_cyc = 0, mon_done_cyc = 0, mon_start_cyc = 0;
    int         mon_last_rx_cyc = 0, mon_gap_min = 1000;
    logic [7:0] rx_log[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            m_active = 0; m_fin = 0; m_fly = 0; m_left = 0; m_load_at = 0;
            m_start_at = -100; m_rx_at = -100; m_done_at = -100;
            m_din = 8'h00; m_rx = 8'h00;
        end else if (m_active && m_fin && cyc == m_done_at) begin
            m_active = 0;
            m_fin    = 0;
        end

        e_txr = m_active && !m_fly && !m_fin && (cyc >= m_load_at);
        chk("cs_n",        int'(bus_if.cs_n),        int'(!m_active));
        chk("cmd_ready",   int'(bus_if.cmd_ready),   int'(!m_active));
        chk("busy",        int'(bus_if.busy),        int'(m_active));
        chk("tx_ready",    int'(bus_if.tx_ready),    int'(e_txr));
        chk("spi_start",   int'(bus_if.spi_start),   int'(cyc == m_start_at));
        chk("rx_valid",    int'(bus_if.rx_valid),    int'(cyc == m_rx_at));
        chk("done",        int'(bus_if.done),        int'(cyc == m_done_at));
        chk("rx_data",     int'(bus_if.rx_data),     int'(m_rx));
        chk("spi_data_in", int'(bus_if.spi_data_in), int'(m_din));

        if (bus_if.spi_start) begin
            mon_start++;
            mon_start_cyc = cyc;
            if (mon_last_rx_cyc > 0 && cyc - mon_last_rx_cyc < mon_gap_min)
                mon_gap_min = cyc - mon_last_rx_cyc;
        end
        if (bus_if.rx_valid) begin
            mon_rx++;
            mon_last_rx_cyc = cyc;
            rx_log.push_back(bus_if.rx_data);
        end
        if (bus_if.done) begin
            mon_done++;
            mon_done_cyc = cyc;
        end
        if (!bus_if.cs_n) mon_cs_low++;
        if (rst && bus_if.cmd_valid && bus_if.cmd_ready) mon_acc_cyc = cyc;

        if (rst) begin
            if (!m_active) begin
                if (bus_if.cmd_valid) begin
                    if (bus_if.cmd_len == 8'd0) begin
                        m_done_at = cyc + 1;
                    end else begin
                        m_active  = 1;
                        m_left    = int'(bus_if.cmd_len);
                        m_load_at = cyc + 1 + CS_SETUP;
                    end
                end
            end else if (e_txr && bus_if.tx_valid) begin
                m_fly      = 1;
                m_start_at = cyc + 1;
                m_din      = bus_if.tx_data;
            end else if (m_fly && cyc >= m_start_at && bus_if.spi_new_data) begin
                m_fly   = 0;
                m_rx_at = cyc + 1;
                m_rx    = bus_if.spi_data_out;
                m_left--;
                if (m_left == 0) begin
                    m_fin     = 1;
                    m_done_at = cyc + CS_HOLD + 1;
                end else begin
                    m_load_at = cyc + GAP + 1;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_cmd(input logic [7:0] len, input bit keep);
        bit r, ok;
        ok = 0;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_len   = len;
        for (int i = 0; i < 200; i++) begin
            r = bus_if.cmd_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        if (!keep) bus_if.cmd_valid = 1'b0;
        if (!ok) timeout("cmd_accept");
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit r, ok;
        ok = 0;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = b;
        for (int i = 0; i < 200; i++) begin
            r = bus_if.tx_ready;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1;
                break;
            end
        end
        bus_if.tx_valid = 1'b0;
        if (!ok) timeout("tx_accept");
    endtask

    task automatic wait_done();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (bus_if.done) begin
                ok = 1;
                bus_if.cmd_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
        bus_if.cmd_valid = 1'b0;
        if (!ok) timeout("done_wait");
    endtask

    int b_start, b_rx, b_done, b_cs;

    task automatic snap();
        b_start = mon_start;
        b_rx    = mon_rx;
        b_done  = mon_done;
        b_cs    = mon_cs_low;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_len   = 8'd0;
        bus_if.tx_valid  = 1'b0;
        bus_if.tx_data   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_cs_n",      int'(bus_if.cs_n), 1);
        chk("reset_cmd_ready", int'(bus_if.cmd_ready), 1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 1: single byte loopback
        snap();
        send_cmd(8'd1, 1'b0);
        send_byte(8'hA5);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("t1_starts", mon_start - b_start, 1);
        chk("t1_rx_cnt", mon_rx - b_rx, 1);
        chk("t1_rx_dat", int'(rx_log[b_rx]), 'hA5);
        chk("t1_done",   mon_done - b_done, 1);
        chk("t1_acc_to_start", mon_start_cyc - mon_acc_cyc, 6);
        chk("t1_acc_to_done",  mon_done_cyc - mon_acc_cyc, 14);
        chk("t1_cs_low", mon_cs_low - b_cs, 13);

        // 2: four bytes with inter-byte gap
        snap();
        send_cmd(8'd4, 1'b0);
        for (int i = 1; i <= 4; i++) send_byte(8'(i));
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("t2_starts", mon_start - b_start, 4);
        chk("t2_rx_cnt", mon_rx - b_rx, 4);
        for (int i = 0; i < 4; i++) chk("t2_rx_dat", int'(rx_log[b_rx + i]), i + 1);
        chk("t2_cs_low", mon_cs_low - b_cs, 34);
        chk("t2_acc_to_done", mon_done_cyc - mon_acc_cyc, 35);
        chk("t2_rx_to_start", mon_gap_min, 3);

        // 3: zero-length command
        snap();
        send_cmd(8'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_done", mon_done - b_done, 1);
        chk("t3_acc_to_done", mon_done_cyc - mon_acc_cyc, 1);
        chk("t3_starts", mon_start - b_start, 0);
        chk("t3_cs_low", mon_cs_low - b_cs, 0);

        // 4+6: TX stall with cmd_valid held and a spurious engine strobe in LOAD
        snap();
        send_cmd(8'd3, 1'b1);
        bus_if.cmd_len = 8'd7;
        send_byte(8'h11);
        repeat (15) @(posedge clk);
        #1;
        spur_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_cs_held",     int'(bus_if.cs_n), 0);
        chk("t4_stall_start", mon_start - b_start, 1);
        chk("t4_spur_rx",     mon_rx - b_rx, 1);
        send_byte(8'h22);
        send_byte(8'h33);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("t4_starts", mon_start - b_start, 3);
        chk("t4_rx_cnt", mon_rx - b_rx, 3);
        chk("t4_rx_0", int'(rx_log[b_rx]), 'h11);
        chk("t4_rx_1", int'(rx_log[b_rx + 1]), 'h22);
        chk("t4_rx_2", int'(rx_log[b_rx + 2]), 'h33);
        chk("t4_done", mon_done - b_done, 1);

        // 5: asynchronous reset during byte 2 of 4
        snap();
        send_cmd(8'd4, 1'b0);
        send_byte(8'h41);
        send_byte(8'h42);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("t5_cs_async",   int'(bus_if.cs_n), 1);
        chk("t5_cmd_ready",  int'(bus_if.cmd_ready), 1);
        chk("t5_busy",       int'(bus_if.busy), 0);
        chk("t5_rx_valid",   int'(bus_if.rx_valid), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t5_no_done", mon_done - b_done, 0);
        chk("t5_rx_cnt",  mon_rx - b_rx, 1);
        send_cmd(8'd1, 1'b0);
        send_byte(8'h5A);
        wait_done();
        repeat (2) @(posedge clk);
        #1;
        chk("t5_after_rx",   mon_rx - b_rx, 2);
        chk("t5_after_dat",  int'(rx_log[b_rx + 1]), 'h5A);
        chk("t5_after_done", mon_done - b_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
